// File: rtl/multi_port_input_buffer_if.sv
// -----------------------------------------------------------------------------
// multi_port_input_buffer_if
// Bus bundle for the multi-port debugger input stage.
//   master : traffic/config source (drives enqueue, eof_in, vector_in, tracing,
//            configId, configData; observes the emission outputs)
//   slave  : the input buffer itself
// Emission side: valid_out, eof_out, bof_out, vector_out, chainId_out,
// port_out, plus the sticky per-port overflow flags.
// -----------------------------------------------------------------------------
interface multi_port_input_buffer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int MAX_CHAINS = 4
);
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]                        enqueue;
  logic [NUM_PORTS-1:0][1:0]                   eof_in;
  logic [NUM_PORTS-1:0][N-1:0][DATA_WIDTH-1:0] vector_in;
  logic                                        tracing;
  logic [7:0]                                  configId;
  logic [7:0]                                  configData;

  logic                                        valid_out;
  logic [1:0]                                  eof_out;
  logic [1:0]                                  bof_out;
  logic [N-1:0][DATA_WIDTH-1:0]                vector_out;
  logic [CW-1:0]                               chainId_out;
  logic [PW-1:0]                               port_out;
  logic [NUM_PORTS-1:0]                        overflow;

  modport master (
    output enqueue, eof_in, vector_in, tracing, configId, configData,
    input  valid_out, eof_out, bof_out, vector_out, chainId_out, port_out, overflow
  );

  modport slave (
    input  enqueue, eof_in, vector_in, tracing, configId, configData,
    output valid_out, eof_out, bof_out, vector_out, chainId_out, port_out, overflow
  );
endinterface

// File: rtl/multi_port_input_buffer.sv
// -----------------------------------------------------------------------------
// multi_port_input_buffer
// NUM_PORTS traced input streams, each with its own FIFO. A round-robin
// arbiter picks one head vector at a time and replays it once per active
// chain (num_chains, 1..MAX_CHAINS), tagging each emission with chainId and
// source port. Configuration (num_chains, overflow clear) arrives over the
// shared tracing/configId/configData bus while tracing=0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : multi_port_input_buffer_if.slave (see interface header)
// -----------------------------------------------------------------------------

// Per-port FIFO. head_nxt_o exposes the entry behind the head so the arbiter
// can re-grant the same port in the cycle it is popped without a bubble.
module mpib_port_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            din_i,
  output logic [W-1:0]            head_o,
  output logic [W-1:0]            head_nxt_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    drop_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]   count_q;
  logic          accept;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept     = wr_i && ((count_q < CNW'(DEPTH)) || pop_i);
  assign drop_o     = wr_i && !accept;
  assign rd_nxt     = rd_ptr_q + AW'(1);
  assign head_o     = mem_q[rd_ptr_q];
  assign head_nxt_o = mem_q[rd_nxt];
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_nxt;
      count_q <= count_q + CNW'(accept) - CNW'(pop_i);
    end
  end
endmodule

module multi_port_input_buffer #(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int NUM_PORTS          = 4,
  parameter int IB_DEPTH           = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int INITIAL_FIRMWARE   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  multi_port_input_buffer_if.slave  bus
);
  localparam int CW   = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int PW   = $clog2(NUM_PORTS);
  localparam int NW   = $clog2(MAX_CHAINS) + 1;
  localparam int VW   = N * DATA_WIDTH;
  localparam int EW   = VW + 2;
  localparam int CNTW = $clog2(IB_DEPTH) + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                         state_q;
  logic                           valid_q;
  logic [1:0]                     eof_q, bof_out_q;
  logic [VW-1:0]                  vec_q;
  logic [CW-1:0]                  chain_q;
  logic [PW-1:0]                  port_q, rr_q;
  logic [NUM_PORTS-1:0]           ovf_q;
  logic [NUM_PORTS-1:0][1:0]      bof_q;
  logic [NW-1:0]                  nch_q, gnch_q;

  logic [NUM_PORTS-1:0][EW-1:0]   head, head_nxt;
  logic [NUM_PORTS-1:0][CNTW-1:0] count;
  logic [NUM_PORTS-1:0]           wr, pop, drop, avail;

  logic                           last, grant, gnt_found, cfg_wr;
  logic [PW-1:0]                  gnt_idx, idx_w, rr_nxt;
  logic [EW-1:0]                  sel_ent;
  logic [1:0]                     sel_bof;
  logic [NW-1:0]                  cfg_nch;
  int                             idx;

  assign wr = bus.enqueue & {NUM_PORTS{bus.tracing}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    mpib_port_fifo #(.W(EW), .DEPTH(IB_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr_i       (wr[p]),
      .pop_i      (pop[p]),
      .din_i      ({bus.eof_in[p], bus.vector_in[p]}),
      .head_o     (head[p]),
      .head_nxt_o (head_nxt[p]),
      .count_o    (count[p]),
      .drop_o     (drop[p])
    );
  end

  // Final replay of the current vector: pop its FIFO and re-arbitrate.
  assign last = (state_q == EMIT) && (NW'(chain_q) == gnch_q - NW'(1));

  always_comb begin
    pop   = '0;
    avail = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pop[p]   = last && (port_q == PW'(p));
      // The entry being popped this cycle is no longer eligible.
      avail[p] = count[p] > CNTW'(pop[p]);
    end
  end

  // Round-robin: first eligible port at or after rr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx   = (int'(rr_q) + i) % NUM_PORTS;
      idx_w = PW'(idx);
      if (!gnt_found && avail[idx_w]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_w;
      end
    end
  end

  assign grant  = bus.tracing && gnt_found && ((state_q == IDLE) || last);
  assign rr_nxt = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);

  // Re-granting the port being popped: take the next entry, and its frame
  // state is the eof of the vector leaving now (bof_q updates only at the edge).
  assign sel_ent = pop[gnt_idx] ? head_nxt[gnt_idx] : head[gnt_idx];
  assign sel_bof = pop[gnt_idx] ? eof_q : bof_q[gnt_idx];

  assign cfg_wr = !bus.tracing && (bus.configId == 8'(PERSONAL_CONFIG_ID));

  always_comb begin
    if (bus.configData == 8'd0)                    cfg_nch = NW'(1);
    else if (bus.configData > 8'(MAX_CHAINS))      cfg_nch = NW'(MAX_CHAINS);
    else                                           cfg_nch = NW'(bus.configData);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      eof_q     <= '0;
      bof_out_q <= '0;
      vec_q     <= '0;
      chain_q   <= '0;
      port_q    <= '0;
      rr_q      <= '0;
      ovf_q     <= '0;
      bof_q     <= {NUM_PORTS{2'b11}};
      nch_q     <= NW'(INITIAL_FIRMWARE);
      gnch_q    <= NW'(1);
    end else begin
      if (cfg_wr) nch_q <= cfg_nch;
      ovf_q <= cfg_wr ? '0 : (ovf_q | drop);
      if (last) bof_q[port_q] <= eof_q;

      if (grant) begin
        state_q   <= EMIT;
        valid_q   <= 1'b1;
        chain_q   <= '0;
        port_q    <= gnt_idx;
        rr_q      <= rr_nxt;
        vec_q     <= sel_ent[VW-1:0];
        eof_q     <= sel_ent[EW-1:VW];
        bof_out_q <= sel_bof;
        gnch_q    <= nch_q;
      end else if ((state_q == EMIT) && !last) begin
        valid_q <= 1'b1;
        chain_q <= chain_q + CW'(1);
      end else begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.eof_out     = eof_q;
  assign bus.bof_out     = bof_out_q;
  assign bus.vector_out  = vec_q;
  assign bus.chainId_out = chain_q;
  assign bus.port_out    = port_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_multi_port_input_buffer.sv
module tb_multi_port_input_buffer;
  typedef logic [7:0][31:0] vec_t;
  typedef struct {
    vec_t       v;
    logic [1:0] eof;
    logic [1:0] bof;
    logic [1:0] ch;
    logic [1:0] pt;
    int         cyc;
  } em_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  em_t  q[$];
  em_t  e;

  multi_port_input_buffer_if bus_if ();

  multi_port_input_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Emission log, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_if.valid_out && !reset) begin
      e.v   = bus_if.vector_out;
      e.eof = bus_if.eof_out;
      e.bof = bus_if.bof_out;
      e.ch  = bus_if.chainId_out;
      e.pt  = bus_if.port_out;
      e.cyc = cyc;
      q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input int id);
    vec_t v;
    for (int l = 0; l < 8; l++) v[l] = 32'(id * 256 + l);
    return v;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] d);
    bus_if.tracing    = 1'b0;
    bus_if.configId   = 8'd0;
    bus_if.configData = d;
    tick();
    bus_if.configId   = 8'hFF;
    bus_if.tracing    = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 256'(bus_if.valid_out), 256'(0));
    check({tag, "_eof"},   256'(bus_if.eof_out), 256'(0));
    check({tag, "_bof"},   256'(bus_if.bof_out), 256'(0));
    check({tag, "_vec"},   256'(bus_if.vector_out), 256'(0));
    check({tag, "_chain"}, 256'(bus_if.chainId_out), 256'(0));
    check({tag, "_port"},  256'(bus_if.port_out), 256'(0));
    check({tag, "_ovf"},   256'(bus_if.overflow), 256'(0));
  endtask

  initial begin
    int n;
    int found;
    logic [1:0] pat [5];
    logic       b0 [5];
    logic       b1 [5];
    int         k1, k3;

    pat = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
    b0  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    b1  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset             = 1'b1;
    bus_if.enqueue    = '0;
    bus_if.eof_in     = '0;
    bus_if.vector_in  = '0;
    bus_if.tracing    = 1'b1;
    bus_if.configId   = 8'hFF;
    bus_if.configData = 8'd0;

    // ---- reset state and single vector latency ----
    do_reset();
    check_idle_outputs("rst");
    bus_if.enqueue[0]   = 1'b1;
    bus_if.vector_in[0] = mk(1);
    bus_if.eof_in[0]    = 2'b00;
    tick();
    bus_if.enqueue = '0;
    tick();
    check("t1_valid", 256'(bus_if.valid_out), 256'(1));
    check("t1_vec",   256'(bus_if.vector_out), 256'(mk(1)));
    check("t1_port",  256'(bus_if.port_out), 256'(0));
    check("t1_chain", 256'(bus_if.chainId_out), 256'(0));
    check("t1_bof",   256'(bus_if.bof_out), 256'(2'b11));
    tick();
    check("t1_valid_off", 256'(bus_if.valid_out), 256'(0));

    // ---- 3 chains, 4 ports at once: 12 back-to-back emissions ----
    do_reset();
    q.delete();
    cfg(8'd3);
    bus_if.enqueue = 4'b1111;
    for (int p = 0; p < 4; p++) bus_if.vector_in[p] = mk(16 + p);
    bus_if.eof_in = '0;
    tick();
    bus_if.enqueue = '0;
    tick(16);
    check("t2_count", 256'(q.size()), 256'(12));
    for (int i = 0; i < 12 && i < q.size(); i++) begin
      check($sformatf("t2_port%0d", i),  256'(q[i].pt), 256'(i / 3));
      check($sformatf("t2_chain%0d", i), 256'(q[i].ch), 256'(i % 3));
      check($sformatf("t2_vec%0d", i),   256'(q[i].v),  256'(mk(16 + i / 3)));
      check($sformatf("t2_cyc%0d", i),   256'(q[i].cyc - q[0].cyc), 256'(i));
    end

    // ---- clamp: 0 -> 1 chain, 9 -> 4 chains ----
    q.delete();
    cfg(8'd0);
    bus_if.enqueue[0] = 1'b1;
    bus_if.vector_in[0] = mk(32);
    tick();
    bus_if.enqueue = '0;
    tick(8);
    check("t3_cfg0_count", 256'(q.size()), 256'(1));
    q.delete();
    cfg(8'd9);
    bus_if.enqueue[0] = 1'b1;
    bus_if.vector_in[0] = mk(33);
    tick();
    bus_if.enqueue = '0;
    tick(10);
    check("t3_cfg9_count", 256'(q.size()), 256'(4));
    for (int i = 0; i < 4 && i < q.size(); i++)
      check($sformatf("t3_chain%0d", i), 256'(q[i].ch), 256'(i));

    // ---- overflow on port 2 with 4 chains ----
    q.delete();
    for (int i = 0; i < 48; i++) begin
      bus_if.enqueue      = 4'b0100;
      bus_if.vector_in[2] = mk(256 + i);
      tick();
    end
    bus_if.enqueue = '0;
    check("t4_ovf_set", 256'(bus_if.overflow), 256'(4'b0100));
    tick(220);
    n = 0;
    foreach (q[i]) begin
      if (q[i].ch == 2'd0) begin
        if (n < 32) check($sformatf("t4_vec%0d", n), 256'(q[i].v), 256'(mk(256 + n)));
        n++;
      end
    end
    check("t4_ge32", 256'(n >= 32), 256'(1));
    cfg(8'd4);
    check("t4_ovf_clr", 256'(bus_if.overflow), 256'(0));

    // ---- bof tracking on port 1 with port 3 interleaved ----
    do_reset();
    q.delete();
    for (int i = 0; i < 5; i++) begin
      bus_if.enqueue      = 4'b1010;
      bus_if.vector_in[1] = mk(64 + i);
      bus_if.eof_in[1]    = pat[i];
      bus_if.vector_in[3] = mk(80 + i);
      bus_if.eof_in[3]    = 2'b11;
      tick();
    end
    bus_if.enqueue = '0;
    bus_if.eof_in  = '0;
    tick(15);
    k1 = 0;
    k3 = 0;
    foreach (q[i]) begin
      if (q[i].pt == 2'd1 && k1 < 5) begin
        check($sformatf("t5_vec%0d", k1),  256'(q[i].v), 256'(mk(64 + k1)));
        check($sformatf("t5_bof0_%0d", k1), 256'(q[i].bof[0]), 256'(b0[k1]));
        check($sformatf("t5_bof1_%0d", k1), 256'(q[i].bof[1]), 256'(b1[k1]));
        k1++;
      end else if (q[i].pt == 2'd3) begin
        check($sformatf("t5_p3bof%0d", k3), 256'(q[i].bof), 256'(2'b11));
        k3++;
      end
    end
    check("t5_p1_count", 256'(k1), 256'(5));
    check("t5_p3_count", 256'(k3), 256'(5));

    // ---- tracing drop mid-replay, then reset mid-emission ----
    cfg(8'd4);
    bus_if.enqueue[0]   = 1'b1;
    bus_if.vector_in[0] = mk(96);
    tick();
    bus_if.vector_in[0] = mk(97);
    tick();
    bus_if.enqueue = '0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.valid_out && bus_if.chainId_out == 2'd1) begin
        found = 1;
        break;
      end
      tick();
    end
    check("t6_saw_chain1", 256'(found), 256'(1));
    bus_if.tracing = 1'b0;
    tick();
    check("t6_c2_valid", 256'(bus_if.valid_out), 256'(1));
    check("t6_c2_chain", 256'(bus_if.chainId_out), 256'(2));
    tick();
    check("t6_c3_valid", 256'(bus_if.valid_out), 256'(1));
    check("t6_c3_chain", 256'(bus_if.chainId_out), 256'(3));
    tick();
    check("t6_stop", 256'(bus_if.valid_out), 256'(0));
    tick(3);
    check("t6_hold", 256'(bus_if.valid_out), 256'(0));
    bus_if.tracing = 1'b1;
    found = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.valid_out) begin
        found = 1;
        break;
      end
    end
    check("t6_resume", 256'(found), 256'(1));
    check("t6_retained_vec", 256'(bus_if.vector_out), 256'(mk(97)));
    check("t6_retained_chain", 256'(bus_if.chainId_out), 256'(0));
    bus_if.enqueue[1]   = 1'b1;
    bus_if.vector_in[1] = mk(98);
    tick();
    bus_if.enqueue = '0;
    check("t6_mid_emit", 256'(bus_if.valid_out), 256'(1));
    reset = 1'b1;
    tick();
    check_idle_outputs("t6_rst");
    reset = 1'b0;
    q.delete();
    tick(10);
    check("t6_fifo_empty", 256'(q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
